// File: rtl/square_add.sv
// ---------------------------------------------------------------------------
// square_add
//   Last stage of the y = a^2 + b^(1/3) datapath. Latches operand a and the
//   cube root r from the upstream stage, squares a with a sequential
//   shift-add multiplier (one multiplier bit per cycle), then adds r through
//   the very same adder and publishes y = a^2 + r.
//
//   Ports
//     clk     rising-edge clock
//     rst     asynchronous, active-high reset
//     start   request, sampled only while idle
//     a_in    operand to be squared (WIDTH bits)
//     r_in    root from the cube-root stage (WIDTH bits)
//     y_out   a^2 + r (2*WIDTH bits), held until the next completion
//     busy_o  high while an operation is in flight
//     done_o  one-cycle pulse on the cycle y_out updates
//
//   Build option
//     SQUARE_ADD_EARLY_EXIT_EN  when defined, the squaring phase also ends as
//     soon as the remaining multiplier bits are all zero. Results are the
//     same; only latency shrinks for small operands.
// ---------------------------------------------------------------------------
module square_add #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a_in,
    input  logic [WIDTH-1:0]   r_in,
    output logic [2*WIDTH-1:0] y_out,
    output logic               busy_o,
    output logic               done_o
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SQUARE = 2'd1;
    localparam logic [1:0] ADD    = 2'd2;

    logic [1:0]         state;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplr;
    logic [WIDTH-1:0]   root;
    logic [CW-1:0]      cnt;

    // The block's only adder: the partial product in SQUARE, the root in ADD.
    logic [2*WIDTH-1:0] addend;
    logic [2*WIDTH-1:0] sum;
    logic [WIDTH-1:0]   mplr_sh;
    logic [CW-1:0]      cnt_inc;
    logic               sq_last;

    always_comb begin
        addend  = (state == ADD) ? {{WIDTH{1'b0}}, root} : mcand;
        sum     = acc + addend;
        mplr_sh = mplr >> 1;
        cnt_inc = cnt + 1'b1;
`ifdef SQUARE_ADD_EARLY_EXIT_EN
        // Once no multiplier bits remain, further cycles add nothing.
        sq_last = (cnt_inc == CW'(WIDTH)) || (mplr_sh == '0);
`else
        sq_last = (cnt_inc == CW'(WIDTH));
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            acc    <= '0;
            mcand  <= '0;
            mplr   <= '0;
            root   <= '0;
            cnt    <= '0;
            y_out  <= '0;
            busy_o <= 1'b0;
            done_o <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand  <= {{WIDTH{1'b0}}, a_in};
                        mplr   <= a_in;
                        root   <= r_in;
                        acc    <= '0;
                        cnt    <= '0;
                        busy_o <= 1'b1;
                        state  <= SQUARE;
                    end
                end
                SQUARE: begin
                    if (mplr[0])
                        acc <= sum;
                    mcand <= mcand << 1;
                    mplr  <= mplr_sh;
                    cnt   <= cnt_inc;
                    if (sq_last)
                        state <= ADD;
                end
                ADD: begin
                    y_out  <= sum;
                    busy_o <= 1'b0;
                    done_o <= 1'b1;
                    state  <= IDLE;
                end
                default: begin
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_square_add.sv
// Scoreboard bench for square_add: the driver pushes the mathematically
// expected result (a*a + r) and expected busy length for every accepted
// request; an independent monitor pops and compares on each done_o.
module tb_square_add;

    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic [W-1:0]   a_in = '0;
    logic [W-1:0]   r_in = '0;
    logic [2*W-1:0] y_out;
    logic           busy_o;
    logic           done_o;

    square_add #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .a_in(a_in), .r_in(r_in),
        .y_out(y_out), .busy_o(busy_o), .done_o(done_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2*W-1:0] y;
        int             busy;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int failures = 0;

    function automatic int sq_cycles(input int a);
`ifdef SQUARE_ADD_EARLY_EXIT_EN
        int n = 0;
        int v = a;
        while (v != 0) begin n++; v = v >> 1; end
        return (n < 1) ? 1 : n;
`else
        return W;
`endif
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Issue one request; optionally keep start high afterwards or poke a
    // spurious start (with different operands) while the op is in flight.
    task automatic issue(input int a, input int r, input bit hold, input bit poke);
        int guard = 0;
        exp_t e;
        @(negedge clk);
        while (busy_o && guard < 50) begin @(negedge clk); guard++; end
        check("issue_wait_timeout", guard >= 50, 0);
        a_in  = W'(a);
        r_in  = W'(r);
        start = 1'b1;
        e.y    = (2*W)'(a * a + r);
        e.busy = sq_cycles(a) + 1;
        q.push_back(e);
        @(negedge clk);
        if (!hold) start = 1'b0;
        a_in = W'($urandom);
        r_in = W'($urandom);
        if (poke) begin
            @(negedge clk);
            if (busy_o) begin
                a_in  = W'(9);
                r_in  = W'(9);
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
        end
    endtask

    task automatic drain();
        int guard = 0;
        while (q.size() != 0 && guard < 200) begin @(negedge clk); guard++; end
        check("drain_timeout", guard >= 200, 0);
    endtask

    // Monitor
    int busy_cnt = 0;
    logic [2*W-1:0] last_y = '0;
    logic prev_done = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            busy_cnt  = 0;
            last_y    = '0;
            prev_done = 1'b0;
        end else begin
            if (done_o) begin
                if (q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("y_out", y_out, e.y);
                    check("busy_cycles", busy_cnt, e.busy);
                    check("busy_low_at_done", busy_o, 0);
                end
                check("done_single_pulse", prev_done, 0);
                busy_cnt = 0;
                last_y = y_out;
            end else begin
                if (y_out != last_y) check("y_out_stable", y_out, last_y);
                if (busy_o) busy_cnt++;
            end
            prev_done = done_o;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_y_out", y_out, 0);
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);

        // Directed cases
        issue(0, 0, 0, 0);
        drain();
        issue(255, 255, 0, 0);
        drain();
        issue(12, 3, 1, 0);      // start held high into the next request
        issue(6, 6, 0, 0);
        drain();
        issue(7, 4, 0, 1);       // spurious start mid-op must be ignored
        drain();
        issue(1, 0, 0, 0);
        issue(128, 5, 0, 0);
        drain();

        // Reset mid-operation aborts with no done_o
        issue(200, 17, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_y_out", y_out, 0);
        check("abort_busy", busy_o, 0);
        check("abort_done", done_o, 0);
        q.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("post_abort_done", done_o, 0);
        issue(2, 1, 0, 0);
        drain();

        // Randomized traffic
        for (int i = 0; i < 60; i++) begin
            int gap = $urandom_range(0, 3);
            repeat (gap) @(negedge clk);
            issue($urandom_range(0, 255), $urandom_range(0, 255),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0));
        end
        start = 1'b0;
        drain();
        repeat (3) @(negedge clk);
        check("queue_empty", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
